uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_serializer.sv | 36 +++
 rtl/uart_tx.sv | 77 +++++++
 tb/tb_uart_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and default payload width, shared by the TX and RX sides
package uart_pkg;
   localparam int UART_DATA_WIDTH = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload load/shift register plus data-bit counter with a last-bit flag
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  shift_i,
   input  logic                  count_i,
   output logic                  bit_o,
   output logic                  done_o
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   assign bit_o  = shreg_q[0];
   assign done_o = cnt_q == CW'(DATA_WIDTH - 1);
   // Load wins; otherwise shift toward the LSB and count data cycles, wrapping to 0 on the last one
   always_comb begin
      shreg_d = load_i ? data_i : shift_i ? shreg_q >> 1 : shreg_q;
      cnt_d   = load_i ? '0 : count_i ? (done_o ? '0 : cnt_q + 1'b1) : cnt_q;
   end
   // Shift register and counter state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: framing FSM, running parity and registered line/busy outputs around the serializer
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);
   uart_state_e state_q, state_d;
   logic par_en_q, par_en_d, par_q, par_d;
   logic tx_d, busy_d, load, shift, count, ser_bit, ser_done;
   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (load),
      .data_i  (P_DATA),
      .shift_i (shift),
      .count_i (count),
      .bit_o   (ser_bit),
      .done_o  (ser_done)
   );
   // Next state, and outputs computed for the next state so the line flops switch with the FSM;
   // parity starts at the latched type and folds in each data bit as it leaves the shifter
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            load    = Data_Valid;
            state_d = Data_Valid ? START : IDLE;
         end
         START: begin
            shift   = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            shift   = !ser_done;
            state_d = !ser_done ? DATA : par_en_q ? PARITY : STOP;
         end
         PARITY: state_d = STOP;
         STOP: begin
            load    = Data_Valid;
            state_d = Data_Valid ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
      count    = state_q == DATA;
      par_en_d = load ? PAR_EN : par_en_q;
      par_d    = load ? PAR_TYP : shift ? par_q ^ ser_bit : par_q;
      tx_d     = state_d == START ? 1'b0 : state_d == DATA ? ser_bit : state_d == PARITY ? par_q : 1'b1;
      busy_d   = state_d != IDLE;
   end
   // State, latched frame options and registered outputs; reset forces the line high at once
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         TX_OUT   <= 1'b1;
         Busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         TX_OUT   <= tx_d;
         Busy     <= busy_d;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames checked against a queue-of-bits line model and hand-computed frames
module tb_uart_tx;
   localparam int DW = 8;
   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          TX_OUT, Busy;
   int            tests = 0;
   int            fails = 0;
   bit            chk_en = 1'b0;
   logic          m_tx = 1'b1;
   logic          m_busy = 1'b0;
   bit            mq[$];

   always #5 CLK = ~CLK;

   uart_tx #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line model: a request is taken only when no frame bits remain queued after the current cycle
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mq.delete();
         m_tx   <= 1'b1;
         m_busy <= 1'b0;
      end else begin
         if (Data_Valid && mq.size() == 0) begin
            mq.push_back(1'b0);
            for (int i = 0; i < DW; i++) mq.push_back(P_DATA[i]);
            if (PAR_EN) mq.push_back(PAR_TYP ^ (^P_DATA));
            mq.push_back(1'b1);
         end
         if (mq.size() != 0) begin
            m_tx   <= mq.pop_front();
            m_busy <= 1'b1;
         end else begin
            m_tx   <= 1'b1;
            m_busy <= 1'b0;
         end
      end
   end

   // Every cycle, the DUT line and busy flag must follow the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("model_tx", TX_OUT, m_tx);
         chk("model_busy", Busy, m_busy);
      end
   end

   task automatic frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int inj,
                        input logic [DW-1:0] inj_d, output logic [23:0] bits, output int nbusy);
      @(negedge CLK);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      nbusy      = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         bits[i]    = TX_OUT;
         nbusy     += int'(Busy);
         Data_Valid = (i == inj);
         P_DATA     = (i == inj) ? inj_d : DW'($urandom);
         PAR_EN     = (i == inj) ? pe : 1'($urandom_range(0, 1));
         PAR_TYP    = (i == inj) ? pt : 1'($urandom_range(0, 1));
      end
      Data_Valid = 1'b0;
   endtask

   initial begin
      logic [23:0] b;
      int          nb;
      repeat (2) @(negedge CLK);
      chk("reset_tx", TX_OUT, 1);
      chk("reset_busy", Busy, 0);
      RST    = 1'b1;
      chk_en = 1'b1;
      frame(8'hA5, 1'b1, 1'b0, -1, 8'h00, b, nb);
      chk("a5_even_bits", b[10:0], 11'b10101001010);
      chk("a5_even_busy", nb, 11);
      chk("a5_even_idle", b[23:11], 13'h1fff);
      frame(8'hA5, 1'b1, 1'b1, -1, 8'h00, b, nb);
      chk("a5_odd_bits", b[10:0], 11'b11101001010);
      chk("a5_odd_busy", nb, 11);
      frame(8'h3C, 1'b0, 1'b0, -1, 8'h00, b, nb);
      chk("3c_nopar_bits", b[9:0], 10'b1001111000);
      chk("3c_nopar_busy", nb, 10);
      chk("3c_nopar_idle", b[23:10], 14'h3fff);
      frame(8'h55, 1'b1, 1'b0, 10, 8'hF0, b, nb);
      chk("b2b_first_bits", b[10:0], 11'b10010101010);
      chk("b2b_second_start", b[11], 0);
      chk("b2b_second_bits", b[21:11], 11'b10111100000);
      chk("b2b_busy", nb, 22);
      frame(8'h00, 1'b0, 1'b0, 3, 8'hFF, b, nb);
      chk("ignore_bits", b[9:0], 10'b1000000000);
      chk("ignore_busy", nb, 10);
      chk("ignore_idle", b[23:10], 14'h3fff);
      @(negedge CLK);
      P_DATA     = 8'h00;
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (4) @(negedge CLK);
      chk("pre_reset_tx", TX_OUT, 0);
      chk("pre_reset_busy", Busy, 1);
      #2 RST = 1'b0;
      #1;
      chk("rst_async_tx", TX_OUT, 1);
      chk("rst_async_busy", Busy, 0);
      @(posedge CLK);
      #1;
      chk("rst_hold_tx", TX_OUT, 1);
      chk("rst_hold_busy", Busy, 0);
      @(negedge CLK);
      RST = 1'b1;
      frame(8'h81, 1'b1, 1'b1, -1, 8'h00, b, nb);
      chk("post_rst_bits", b[10:0], 11'b11100000010);
      chk("post_rst_busy", nb, 11);
      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
